serial_adder: RTL and testbench

Bit-serial N-bit adder that accepts two parallel operands and a carry-in through a valid/ready handshake. It feeds the operands LSB-first through a single one-bit full-adder cell, one bit per clock, and keeps the carry in a flip-flop between bits. It reassembles the sum in a shift register and returns it with carry-out through a second valid/ready handshake. It is the sequential stage wrapped around the team's one-bit full adder and trades latency for a single adder cell.

---
 rtl/serial_arith_pkg.sv | 10 +
 rtl/fa_cell.sv | 20 ++
 rtl/serial_adder.sv | 113 +++++++++++
 tb/tb_serial_adder.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/serial_arith_pkg.sv
// Shared constants for the bit-serial arithmetic blocks: FSM encoding and default width.
package serial_arith_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/fa_cell.sv
// One-bit full adder built from two half adders and an OR.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);

  logic hs1_sum;
  logic hs1_carry;
  logic hs2_carry;

  assign hs1_sum   = a ^ b;
  assign hs1_carry = a & b;
  assign sum       = hs1_sum ^ c;
  assign hs2_carry = hs1_sum & c;
  assign carry     = hs1_carry | hs2_carry;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: operands enter in parallel, are added LSB-first through one
// full-adder cell, and the sum is returned in parallel with carry-out.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// SHIFT | one bit added per clock, LSB first
// DONE  | result held on sum/cout with out_valid high until out_ready
module serial_adder
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [1:0]       state_dec;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             fa_sum;
  logic             fa_carry;

  fa_cell u_fa (
    .a     (a_sh_q[0]),
    .b     (b_sh_q[0]),
    .c     (carry_q),
    .sum   (fa_sum),
    .carry (fa_carry)
  );

  // The unused encoding behaves exactly like IDLE.
  assign state_dec = (state_q == ST_SHIFT || state_q == ST_DONE) ? state_q : ST_IDLE;

  always_comb begin
    state_d = state_dec;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    case (state_dec)
      ST_SHIFT: begin
        carry_d = fa_carry;
        sum_d   = {fa_sum, sum_q[WIDTH-1:1]};
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        // Counter parks at the last bit instead of wrapping.
        if (cnt_q == LAST_BIT) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        if (in_valid) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          sum_d   = '0;
          state_d = ST_SHIFT;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_dec == ST_IDLE);
  assign out_valid = (state_dec == ST_DONE);
  assign busy      = (state_dec == ST_SHIFT) || (state_dec == ST_DONE);
  assign sum       = sum_q;
  assign cout      = carry_q;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder at WIDTH=8 and WIDTH=3, checked against plain-integer addition.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       out_ready;
  logic       sel;

  logic       in_ready8, out_valid8, cout8, busy8;
  logic [7:0] sum8;
  logic       in_ready3, out_valid3, cout3, busy3;
  logic [2:0] sum3;

  logic       in_ready_m, out_valid_m, cout_m, busy_m;
  logic [7:0] sum_m;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid & ~sel),
    .in_ready  (in_ready8),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid8),
    .out_ready (out_ready),
    .sum       (sum8),
    .cout      (cout8),
    .busy      (busy8)
  );

  serial_adder #(.WIDTH(3)) u_dut3 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid & sel),
    .in_ready  (in_ready3),
    .a         (a[2:0]),
    .b         (b[2:0]),
    .cin       (cin),
    .out_valid (out_valid3),
    .out_ready (out_ready),
    .sum       (sum3),
    .cout      (cout3),
    .busy      (busy3)
  );

  assign in_ready_m  = sel ? in_ready3  : in_ready8;
  assign out_valid_m = sel ? out_valid3 : out_valid8;
  assign cout_m      = sel ? cout3      : cout8;
  assign busy_m      = sel ? busy3      : busy8;
  assign sum_m       = sel ? {5'b0, sum3} : sum8;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "/in_ready"}, 32'(in_ready_m), 32'd1);
    chk({tag, "/out_valid"}, 32'(out_valid_m), 32'd0);
    chk({tag, "/busy"}, 32'(busy_m), 32'd0);
    chk({tag, "/sum"}, 32'(sum_m), 32'd0);
    chk({tag, "/cout"}, 32'(cout_m), 32'd0);
  endtask

  // Called at a negedge with the selected DUT idle; returns at a negedge with it idle.
  // hold: extra cycles out_ready stays low after out_valid; glitch_at/rst_at: cycle
  // (1 = first cycle after accept) at which to pulse in_valid or rst, 0 = never.
  task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                        input int hold, input int glitch_at, input int rst_at,
                        input string tag);
    int          w;
    int          cyc;
    logic [32:0] total;
    logic [7:0]  exp_sum;
    logic        exp_cout;
    w        = sel ? 3 : 8;
    total    = 33'(av & 8'((1 << w) - 1)) + 33'(bv & 8'((1 << w) - 1)) + 33'(cv);
    exp_sum  = 8'(total & 33'((1 << w) - 1));
    exp_cout = total[w];

    chk({tag, "/ready_before"}, 32'(in_ready_m), 32'd1);
    a         = av;
    b         = bv;
    cin       = cv;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, "/busy_after_accept"}, 32'(busy_m), 32'd1);
    chk({tag, "/ready_after_accept"}, 32'(in_ready_m), 32'd0);

    cyc = 1;
    while (!out_valid_m && cyc < w + 6) begin
      if (rst_at == cyc) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b0;
        chk_reset_vals({tag, "/after_rst"});
        return;
      end
      if (glitch_at == cyc) begin
        in_valid = 1'b1;
        a        = 8'h01;
        b        = 8'h01;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    chk({tag, "/latency"}, 32'(cyc), 32'(w + 1));
    chk({tag, "/sum"}, 32'(sum_m), 32'(exp_sum));
    chk({tag, "/cout"}, 32'(cout_m), 32'(exp_cout));

    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({tag, "/hold_valid"}, 32'(out_valid_m), 32'd1);
      chk({tag, "/hold_sum"}, 32'(sum_m), 32'(exp_sum));
      chk({tag, "/hold_cout"}, 32'(cout_m), 32'(exp_cout));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "/valid_after_hs"}, 32'(out_valid_m), 32'd0);
    chk({tag, "/ready_after_hs"}, 32'(in_ready_m), 32'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    out_ready = 1'b0;
    sel       = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_reset_vals("reset8");
    sel = 1'b1;
    chk_reset_vals("reset3");
    sel = 1'b0;

    run_op(8'h35, 8'h4A, 1'b0, 0, 0, 0, "basic");
    run_op(8'hFF, 8'h01, 1'b0, 0, 0, 0, "carry_out");
    run_op(8'hFF, 8'hFF, 1'b1, 0, 0, 0, "all_ones_cin");
    run_op(8'h35, 8'h4A, 1'b0, 5, 0, 0, "backpressure");

    run_op(8'h35, 8'h4A, 1'b0, 0, 3, 0, "glitch");
    @(negedge clk);
    chk("glitch/not_stored", 32'(busy_m), 32'd0);
    run_op(8'h01, 8'h01, 1'b0, 0, 0, 0, "reissue");

    run_op(8'h35, 8'h4A, 1'b0, 0, 0, 5, "mid_reset");
    run_op(8'h10, 8'h20, 1'b0, 0, 0, 0, "after_reset");

    for (int s = 0; s < 2; s++) begin
      sel = (s == 1);
      for (int n = 0; n < 1000; n++) begin
        run_op(8'($urandom), 8'($urandom), 1'($urandom),
               int'($urandom_range(0, 2)), 0, 0, sel ? "rand3" : "rand8");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
